// File: rtl/tic_tac_referee.sv
// Tic-tac-toe referee: tracks the authoritative board, enforces turn order and
// square legality, and reports win / draw / illegal-move outcomes.
module tic_tac_referee #(
  parameter bit COMP_FIRST = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cMove,
  input  logic       cValid,
  input  logic [3:0] hMove,
  input  logic       hValid,
  output logic [8:0] cBoard,
  output logic [8:0] hBoard,
  output logic       hTurn,
  output logic [3:0] moveCount,
  output logic       cWin,
  output logic       hWin,
  output logic       draw,
  output logic       illegal,
  output logic       illegalBy,
  output logic       gameOver
);

  typedef enum logic [1:0] {StCTurn, StHTurn, StDone} state_t;

  state_t     state;
  logic       is_h;
  logic [3:0] mv;
  logic       in_turn;
  logic       out_turn;
  logic       code_ok;
  logic [8:0] sq;
  logic       occupied;
  logic [8:0] c_next;
  logic [8:0] h_next;
  logic       win;

  // True when the board holds any of the eight three-in-a-row lines.
  function automatic logic has_line(input logic [8:0] b);
    return (&b[2:0]) | (&b[5:3]) | (&b[8:6]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  // Decode the mover's strobe and evaluate the win on the candidate next board.
  always_comb begin
    is_h     = (state == StHTurn);
    mv       = is_h ? hMove : cMove;
    in_turn  = is_h ? hValid : cValid;
    out_turn = is_h ? cValid : hValid;
    code_ok  = (mv >= 4'd1) && (mv <= 4'd9);
    sq       = code_ok ? (9'd1 << (mv - 4'd1)) : 9'd0;
    occupied = |(sq & (cBoard | hBoard));
    c_next   = cBoard | (is_h ? 9'd0 : sq);
    h_next   = hBoard | (is_h ? sq : 9'd0);
    win      = has_line(is_h ? h_next : c_next);
  end

  // Game FSM with all outputs registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= COMP_FIRST ? StCTurn : StHTurn;
      hTurn     <= ~COMP_FIRST;
      cBoard    <= 9'd0;
      hBoard    <= 9'd0;
      moveCount <= 4'd0;
      cWin      <= 1'b0;
      hWin      <= 1'b0;
      draw      <= 1'b0;
      illegal   <= 1'b0;
      illegalBy <= 1'b0;
      gameOver  <= 1'b0;
    end else begin
      case (state)
        StCTurn, StHTurn: begin
          if (out_turn) begin
            // Out-of-turn strobe wins over any simultaneous in-turn move.
            illegal   <= 1'b1;
            illegalBy <= ~is_h;
            gameOver  <= 1'b1;
            state     <= StDone;
          end else if (in_turn) begin
            if (!code_ok || occupied) begin
              illegal   <= 1'b1;
              illegalBy <= is_h;
              gameOver  <= 1'b1;
              state     <= StDone;
            end else begin
              cBoard    <= c_next;
              hBoard    <= h_next;
              moveCount <= moveCount + 4'd1;
              if (win) begin
                cWin     <= ~is_h;
                hWin     <= is_h;
                gameOver <= 1'b1;
                state    <= StDone;
              end else if (moveCount == 4'd8) begin
                draw     <= 1'b1;
                gameOver <= 1'b1;
                state    <= StDone;
              end else begin
                state <= is_h ? StCTurn : StHTurn;
                hTurn <= ~is_h;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tic_tac_referee.sv
// Scoreboard bench: two referees (computer-first and human-first) share one
// stimulus stream; a reference model predicts both every cycle.
module tb_tic_tac_referee;

  typedef struct packed {
    logic [8:0] cb;
    logic [8:0] hb;
    logic       ht;
    logic [3:0] mc;
    logic       cw;
    logic       hw;
    logic       dr;
    logic       il;
    logic       ib;
    logic       go;
  } exp_t;

  typedef struct packed {
    exp_t d1;
    exp_t d0;
  } snap_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] c_move = 4'd0;
  logic       c_valid = 1'b0;
  logic [3:0] h_move = 4'd0;
  logic       h_valid = 1'b0;

  logic [8:0] cb1, hb1, cb0, hb0;
  logic [3:0] mc1, mc0;
  logic       ht1, cw1, hw1, dr1, il1, ib1, go1;
  logic       ht0, cw0, hw0, dr0, il0, ib0, go0;

  always #5 clock = ~clock;

  tic_tac_referee #(.COMP_FIRST(1'b1)) u_dut1 (
    .clock(clock), .reset(reset), .cMove(c_move), .cValid(c_valid),
    .hMove(h_move), .hValid(h_valid), .cBoard(cb1), .hBoard(hb1), .hTurn(ht1),
    .moveCount(mc1), .cWin(cw1), .hWin(hw1), .draw(dr1), .illegal(il1),
    .illegalBy(ib1), .gameOver(go1)
  );

  tic_tac_referee #(.COMP_FIRST(1'b0)) u_dut0 (
    .clock(clock), .reset(reset), .cMove(c_move), .cValid(c_valid),
    .hMove(h_move), .hValid(h_valid), .cBoard(cb0), .hBoard(hb0), .hTurn(ht0),
    .moveCount(mc0), .cWin(cw0), .hWin(hw0), .draw(dr0), .illegal(il0),
    .illegalBy(ib0), .gameOver(go0)
  );

  int n_vec = 0;
  int n_err = 0;
  snap_t sb_q[$];

  // Reference model state, index 1 = computer-first, 0 = human-first.
  int       m_st[2];  // 0 computer turn, 1 human turn, 2 done
  bit       m_ht[2];
  bit [8:0] m_cb[2];
  bit [8:0] m_hb[2];
  int       m_mc[2];
  bit       m_cw[2], m_hw[2], m_dr[2], m_il[2], m_ib[2];

  int lines[8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                      '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  function automatic bit m_win(input bit [8:0] b);
    for (int l = 0; l < 8; l++)
      if (b[lines[l][0]] && b[lines[l][1]] && b[lines[l][2]]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = (i == 1) ? 0 : 1;
      m_ht[i] = (i == 0);
      m_cb[i] = '0; m_hb[i] = '0; m_mc[i] = 0;
      m_cw[i] = 0; m_hw[i] = 0; m_dr[i] = 0; m_il[i] = 0; m_ib[i] = 0;
    end
  endtask

  task automatic m_step(input bit cv, input int cm, input bit hv, input int hm);
    for (int i = 0; i < 2; i++) begin
      if (m_st[i] != 2) begin
        bit human = (m_st[i] == 1);
        bit oot = human ? cv : hv;
        bit mine = human ? hv : cv;
        int code = human ? hm : cm;
        if (oot) begin
          m_il[i] = 1; m_ib[i] = !human; m_st[i] = 2;
        end else if (mine) begin
          if (code < 1 || code > 9 || m_cb[i][code-1] || m_hb[i][code-1]) begin
            m_il[i] = 1; m_ib[i] = human; m_st[i] = 2;
          end else begin
            if (human) m_hb[i][code-1] = 1'b1;
            else m_cb[i][code-1] = 1'b1;
            m_mc[i]++;
            if (m_win(human ? m_hb[i] : m_cb[i])) begin
              if (human) m_hw[i] = 1; else m_cw[i] = 1;
              m_st[i] = 2;
            end else if (m_mc[i] == 9) begin
              m_dr[i] = 1; m_st[i] = 2;
            end else begin
              m_st[i] = human ? 0 : 1;
              m_ht[i] = !human;
            end
          end
        end
      end
    end
  endtask

  function automatic exp_t m_snap(input int i);
    exp_t e;
    e.cb = m_cb[i]; e.hb = m_hb[i]; e.ht = m_ht[i]; e.mc = 4'(m_mc[i]);
    e.cw = m_cw[i]; e.hw = m_hw[i]; e.dr = m_dr[i]; e.il = m_il[i];
    e.ib = m_ib[i]; e.go = (m_st[i] == 2);
    return e;
  endfunction

  task automatic cmp_inst(input string n, input exp_t a, input exp_t e);
    check_eq({n, "_cBoard"}, 32'(a.cb), 32'(e.cb));
    check_eq({n, "_hBoard"}, 32'(a.hb), 32'(e.hb));
    check_eq({n, "_moveCount"}, 32'(a.mc), 32'(e.mc));
    check_eq({n, "_flags"}, {26'd0, a.cw, a.hw, a.dr, a.il, a.go},
             {26'd0, e.cw, e.hw, e.dr, e.il, e.go});
    if (e.il) check_eq({n, "_illegalBy"}, 32'(a.ib), 32'(e.ib));
    if (!e.go) check_eq({n, "_hTurn"}, 32'(a.ht), 32'(e.ht));
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic apply(input bit rst, input bit cv, input int cm, input bit hv, input int hm);
    snap_t s, a;
    @(negedge clock);
    reset = rst; c_valid = cv; c_move = 4'(cm); h_valid = hv; h_move = 4'(hm);
    if (rst) m_reset(); else m_step(cv, cm, hv, hm);
    s.d1 = m_snap(1); s.d0 = m_snap(0);
    sb_q.push_back(s);
    @(posedge clock);
    #1;
    a.d1 = '{cb1, hb1, ht1, mc1, cw1, hw1, dr1, il1, ib1, go1};
    a.d0 = '{cb0, hb0, ht0, mc0, cw0, hw0, dr0, il0, ib0, go0};
    s = sb_q.pop_front();
    cmp_inst("cf1", a.d1, s.d1);
    cmp_inst("cf0", a.d0, s.d0);
    c_valid = 1'b0; h_valid = 1'b0;
  endtask

  task automatic c_mv(input int m); apply(1'b0, 1'b1, m, 1'b0, 0); endtask
  task automatic h_mv(input int m); apply(1'b0, 1'b0, 0, 1'b1, m); endtask
  task automatic do_reset(); apply(1'b1, 1'b0, 0, 1'b0, 0); endtask

  initial begin
    int hseq[5];
    int hexp[5];
    do_reset();
    check_eq("rst_hTurn1", 32'(ht1), 32'd0);
    check_eq("rst_hTurn0", 32'(ht0), 32'd1);
    check_eq("rst_go1", 32'(go1), 32'd0);

    // Computer win on diagonal, then a strobe in DONE is ignored.
    c_mv(5); h_mv(2); c_mv(1); h_mv(3); c_mv(9);
    check_eq("s1_cWin", 32'(cw1), 32'd1);
    check_eq("s1_cBoard", 32'(cb1), 32'b100010001);
    check_eq("s1_hBoard", 32'(hb1), 32'b000000110);
    check_eq("s1_mc", 32'(mc1), 32'd5);
    c_mv(7); apply(1'b0, 1'b0, 0, 1'b0, 0);
    check_eq("s1_hold_cBoard", 32'(cb1), 32'b100010001);
    check_eq("s1_hold_mc", 32'(mc1), 32'd5);

    // Full board draw.
    do_reset();
    c_mv(1); h_mv(2); c_mv(3); h_mv(5); c_mv(4); h_mv(7); c_mv(8); h_mv(6); c_mv(9);
    check_eq("s2_draw", 32'(dr1), 32'd1);
    check_eq("s2_wins", {30'd0, cw1, hw1}, 32'd0);
    check_eq("s2_mc", 32'(mc1), 32'd9);
    check_eq("s2_cBoard", 32'(cb1), 32'b110001101);
    check_eq("s2_hBoard", 32'(hb1), 32'b001110010);

    // Occupied square and bad codes.
    do_reset(); c_mv(5); h_mv(5);
    check_eq("s3_il", {30'd0, il1, ib1}, 32'b11);
    check_eq("s3_cBoard", 32'(cb1), 32'b000010000);
    check_eq("s3_hBoard", 32'(hb1), 32'd0);
    check_eq("s3_mc", 32'(mc1), 32'd1);
    do_reset(); c_mv(0);
    check_eq("s3_c0", {30'd0, il1, ib1}, 32'b10);
    check_eq("s3_c0_mc", 32'(mc1), 32'd0);
    do_reset(); c_mv(12);
    check_eq("s3_c12", {30'd0, il1, ib1}, 32'b10);
    do_reset(); c_mv(10); do_reset(); h_mv(15);

    // Out-of-turn strobes, alone and alongside an in-turn move.
    do_reset(); h_mv(1);
    check_eq("s4_oot", {30'd0, il1, ib1}, 32'b11);
    check_eq("s4_oot_hb", 32'(hb1), 32'd0);
    do_reset(); apply(1'b0, 1'b1, 5, 1'b1, 1);
    check_eq("s4_both", {30'd0, il1, ib1}, 32'b11);
    check_eq("s4_both_cb", 32'(cb1), 32'd0);
    check_eq("s4_both_cf0", {30'd0, il0, ib0}, 32'b10);

    // Human-first game with human win; hTurn alternates before each move.
    do_reset();
    hseq = '{1, 5, 2, 9, 3};
    hexp = '{1, 0, 1, 0, 1};
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("s5_hTurn%0d", k), 32'(ht0), 32'(hexp[k]));
      if (k % 2 == 0) h_mv(hseq[k]); else c_mv(hseq[k]);
    end
    check_eq("s5_hWin", 32'(hw0), 32'd1);
    check_eq("s5_hBoard", 32'(hb0), 32'b000000111);
    check_eq("s5_mc", 32'(mc0), 32'd5);

    // Mid-game reset, then a fresh game.
    do_reset(); c_mv(5); h_mv(2); c_mv(1);
    check_eq("s6_pre_mc", 32'(mc1), 32'd3);
    do_reset();
    check_eq("s6_cb", 32'(cb1), 32'd0);
    check_eq("s6_mc", 32'(mc1), 32'd0);
    check_eq("s6_hTurn", 32'(ht1), 32'd0);
    c_mv(5);
    check_eq("s6_new_cb", 32'(cb1), 32'b000010000);
    check_eq("s6_new_il", 32'(il1), 32'd0);

    // Reset out of DONE, then a short randomized stretch for both instances.
    do_reset();
    for (int k = 0; k < 60; k++) begin
      if (k % 15 == 0) do_reset();
      else apply(1'b0, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 10)),
                 ($urandom_range(0, 3) == 0), int'($urandom_range(0, 10)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
